mmio_uart_tx: RTL

- Memory-mapped UART transmitter on the RV32I core's data bus, directly downstream of the core.
- Consumes `dataWe` / `dataAddr` / `datawData` and returns `rData` plus a select flag for the top-level read mux.
- Buffers bytes in a small FIFO and serialises them 8N1, LSB first, on `tx`.
- The core is single-cycle, so reads are combinational and have no side effects.

---
 rtl/mmio_uart_tx_if.sv | 25 ++
 rtl/mmio_uart_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx_if.sv
// Core data-bus bundle for the memory-mapped UART transmitter.
// The core drives address, data and write enable; the peripheral returns read data and its address-hit flag.
interface mmio_uart_tx_if;
    logic        dataWe;
    logic [31:0] dataAddr;
    logic [31:0] datawData;
    logic [31:0] rData;
    logic        sel;

    modport master (
        output dataWe,
        output dataAddr,
        output datawData,
        input  rData,
        input  sel
    );

    modport slave (
        input  dataWe,
        input  dataAddr,
        input  datawData,
        output rData,
        output sel
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO, sitting on the single-cycle core's data bus.
// Register reads are combinational and have no side effects; all state changes on the rising clock edge.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          CLK_DIV    = 868,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    mmio_uart_tx_if.slave  bus,
    output logic           tx,
    output logic           busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLK_DIV - 1);
    localparam logic [AW:0]   FIFO_FULL   = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    state_t          stateNext;
    logic [CW-1:0]   baudCnt;
    logic [CW-1:0]   baudNext;
    logic [2:0]      bitIdx;
    logic [2:0]      bitNext;
    logic [7:0]      shiftReg;
    logic [7:0]      shiftNext;
    logic            txNext;
    logic            pop;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wrPtr;
    logic [AW-1:0]   rdPtr;
    logic [AW:0]     count;
    logic            full;
    logic            empty;

    logic            en;
    logic            ovf;

    logic            hit;
    logic [1:0]      offset;
    logic            wr;
    logic            txWrite;
    logic            statusWrite;
    logic            ctrlWrite;
    logic            push;
    logic [7:0]      count8;
    logic [31:0]     rdataMux;
    logic            unusedBits;

    assign hit         = (bus.dataAddr[31:4] == BASE_ADDR[31:4]);
    assign offset      = bus.dataAddr[3:2];
    assign wr          = hit & bus.dataWe;
    assign txWrite     = wr && (offset == 2'd0);
    assign statusWrite = wr && (offset == 2'd1);
    assign ctrlWrite   = wr && (offset == 2'd2);

    assign full   = (count == FIFO_FULL);
    assign empty  = (count == '0);
    assign push   = txWrite && !full;
    assign count8 = 8'(count);
    assign busy   = (state != IDLE);

    assign unusedBits = ^{bus.dataAddr[1:0], bus.datawData[31:8]};

    always_comb begin
        rdataMux = '0;
        if (hit) begin
            case (offset)
                2'd1:    rdataMux = {16'b0, count8, 4'b0, ovf, empty, full, busy};
                2'd2:    rdataMux = {31'b0, en};
                default: rdataMux = '0;
            endcase
        end
    end

    assign bus.rData = rdataMux;
    assign bus.sel   = hit;

    // Storage carries no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= bus.datawData[7:0];
        end
    end

    // Fullness for the overflow flag uses the pre-edge count, so a same-edge pop does not rescue the byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            en    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (txWrite && full) begin
                ovf <= 1'b1;
            end else if (statusWrite && bus.datawData[3]) begin
                ovf <= 1'b0;
            end
            if (ctrlWrite) begin
                en <= bus.datawData[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baudCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
        end else begin
            state    <= stateNext;
            tx       <= txNext;
            baudCnt  <= baudNext;
            bitIdx   <= bitNext;
            shiftReg <= shiftNext;
        end
    end

    // Each of START, the eight data bits and STOP lasts exactly CLK_DIV cycles.
    always_comb begin
        stateNext = state;
        txNext    = tx;
        baudNext  = baudCnt;
        bitNext   = bitIdx;
        shiftNext = shiftReg;
        pop       = 1'b0;

        case (state)
            IDLE: begin
                txNext = 1'b1;
                if (en && !empty) begin
                    pop       = 1'b1;
                    shiftNext = mem[rdPtr];
                    txNext    = 1'b0;
                    baudNext  = BAUD_RELOAD;
                    stateNext = START;
                end
            end
            START: begin
                if (baudCnt == '0) begin
                    baudNext  = BAUD_RELOAD;
                    txNext    = shiftReg[0];
                    bitNext   = 3'd0;
                    stateNext = DATA;
                end else begin
                    baudNext = baudCnt - 1'b1;
                end
            end
            DATA: begin
                if (baudCnt == '0) begin
                    baudNext = BAUD_RELOAD;
                    if (bitIdx == 3'd7) begin
                        txNext    = 1'b1;
                        stateNext = STOP;
                    end else begin
                        shiftNext = shiftReg >> 1;
                        txNext    = shiftReg[1];
                        bitNext   = bitIdx + 3'd1;
                    end
                end else begin
                    baudNext = baudCnt - 1'b1;
                end
            end
            STOP: begin
                txNext = 1'b1;
                if (baudCnt == '0) begin
                    baudNext  = '0;
                    stateNext = IDLE;
                end else begin
                    baudNext = baudCnt - 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
                txNext    = 1'b1;
                baudNext  = '0;
            end
        endcase
    end

endmodule
